// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, N steps per operation.
// Result, status and handshake outputs are registered one cycle behind the control state.
module seq_divider #(
  parameter int unsigned N = 8
) (
  input  logic         CLK50M,
  input  logic         RST,
  input  logic         Start,
  input  logic [N-1:0] Dividend,
  input  logic [N-1:0] Divisor,
  output logic [N-1:0] Quotient,
  output logic [N-1:0] Remainder,
  output logic         Busy,
  output logic         Done,
  output logic         DivZero
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  q_reg;
  logic [N-1:0]  d_reg;
  logic [N:0]    r_reg;
  logic [CW-1:0] count;

  logic [N:0]    r_shift;
  logic [N:0]    r_sub;
  logic          r_ge;

  // Trial subtraction for the current restoring step.
  assign r_shift = {r_reg[N-1:0], q_reg[N-1]};
  assign r_ge    = (r_shift >= {1'b0, d_reg});
  assign r_sub   = r_shift - {1'b0, d_reg};

  always_ff @(posedge CLK50M) begin
    if (RST) begin
      state     <= S_IDLE;
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      count     <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivZero   <= 1'b0;
    end else begin
      Done <= 1'b0;
      Busy <= (state == S_RUN);
      case (state)
        S_IDLE: begin
          if (Start) begin
            q_reg <= Dividend;
            d_reg <= Divisor;
            r_reg <= '0;
            count <= '0;
            state <= (Divisor == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          r_reg <= r_ge ? r_sub : r_shift;
          q_reg <= {q_reg[N-2:0], r_ge};
          count <= count + CW'(1);
          if (count == CW'(N - 1)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // A zero divisor skips RUN, so q_reg still holds the captured dividend.
          Done <= 1'b1;
          if (d_reg == '0) begin
            Quotient  <= '1;
            Remainder <= q_reg;
            DivZero   <= 1'b1;
          end else begin
            Quotient  <= q_reg;
            Remainder <= r_reg[N-1:0];
            DivZero   <= 1'b0;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a monitor
// pops and compares on every Done pulse, including the cycle the pulse lands on.
module tb_seq_divider;

  localparam int unsigned N = 8;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_zero;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_count = 0;

  seq_divider #(.N(N)) dut (
    .CLK50M    (clk),
    .RST       (rst),
    .Start     (start),
    .Dividend  (dividend),
    .Divisor   (divisor),
    .Quotient  (quotient),
    .Remainder (remainder),
    .Busy      (busy),
    .Done      (done),
    .DivZero   (div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_count++;
      check("busy_with_done", int'(busy), 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("quotient", int'(quotient), int'(e.q));
        check("remainder", int'(remainder), int'(e.r));
        check("div_zero", int'(div_zero), int'(e.z));
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Drive one Start pulse and record what the DUT must report and when.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] eq, input logic [N-1:0] er, input logic ez);
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    e.q   = eq;
    e.r   = er;
    e.z   = ez;
    e.cyc = cyc + 1 + (ez ? 1 : int'(N) + 1);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int dc;
    int base;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_div_zero", int'(div_zero), 0);

    // 100/7 with the Busy window checked after edges 1..N+1.
    do_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    for (int j = 1; j <= int'(N) + 1; j++) begin
      @(negedge clk);
      check($sformatf("busy_edge%0d", j), int'(busy), (j <= int'(N)) ? 1 : 0);
    end
    drain("op100_7");

    do_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    drain("op255_1");
    do_op(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
    drain("op255_255");
    do_op(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
    drain("op5_9");

    // Divide by zero: Done after edge 1 with no Busy, then a normal op clears the flag.
    do_op(8'h3C, 8'd0, 8'hFF, 8'h3C, 1'b1);
    check("div0_no_busy", int'(busy), 0);
    drain("div0");
    do_op(8'd10, 8'd3, 8'd3, 8'd1, 1'b0);
    drain("op10_3");

    // Start while busy is ignored.
    dc = done_count;
    do_op(8'd200, 8'd13, 8'd15, 8'd5, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1; dividend = 8'd9; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    drain("op200_13");
    repeat (12) @(negedge clk);
    check("ignored_start_done_count", done_count - dc, 1);

    // Reset mid-operation aborts; nothing is expected from the aborted op.
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_abort", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_quotient", int'(quotient), 0);
    check("abort_remainder", int'(remainder), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_div_zero", int'(div_zero), 0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_no_done", int'(done), 0);
    do_op(8'd50, 8'd6, 8'd8, 8'd2, 1'b0);
    drain("op50_6");

    // Start held high: accepts every N+2 cycles.
    @(negedge clk);
    start = 1'b1; dividend = 8'd77; divisor = 8'd10;
    base = cyc;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.q = 8'd7; e.r = 8'd7; e.z = 1'b0;
      e.cyc = base + 1 + k * (int'(N) + 2) + int'(N) + 1;
      sb.push_back(e);
    end
    repeat (25) @(negedge clk);
    start = 1'b0;
    drain("held_start");
    repeat (12) @(negedge clk);
    check("final_pending", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider. It is the inverse-direction companion to the lab's multiplier ALU datapath.
- Accepts N-bit Dividend and Divisor on a Start pulse and produces Quotient and Remainder after N iteration cycles.
- Sits beside the ALU controller. Operands come from registered switch values; results drive the existing hex decoders.
- Start is expected from the debounced-button controller path.

Parameters:
- N, 8, operand/result width in bits (N >= 2).

Ports:
- CLK50M  input  1  system clock; all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high.
- Start  input  1  request; sampled only in IDLE.
- Dividend  input  N  unsigned numerator; captured on accepted Start.
- Divisor  input  N  unsigned denominator; captured on accepted Start.
- Quotient  output  N  result quotient; held until next completion.
- Remainder  output  N  result remainder; held until next completion.
- Busy  output  1  high while a division is in progress (RUN state).
- Done  output  1  single-cycle pulse when results update.
- DivZero  output  1  status flag for the last completed operation: 1 if Divisor was 0; held until next completion.

Behaviour:
- One clock (CLK50M). Reset is synchronous, active-high (RST). No asynchronous logic.
- Reset: state=IDLE; Quotient=0, Remainder=0, Busy=0, Done=0, DivZero=0; internal count, remainder and quotient registers cleared.
- States:
  - IDLE -> RUN on Start=1 with a non-zero divisor.
  - IDLE -> DONE on Start=1 with Divisor=0.
  - RUN -> DONE after N steps.
  - DONE -> IDLE unconditionally.
- Accept (IDLE, Start=1): latch Dividend into shift register Q and Divisor into D; clear partial remainder R (N+1 bits); count=0.
- RUN step, one per cycle:
  - R' = {R[N-1:0], Q[N-1]}; Q shifts left by 1.
  - If R' >= {0,D}: R = R' - {0,D} and Q[0]=1. Else R = R' and Q[0]=0.
  - count increments; after step N-1 the next state is DONE.
- DONE (one cycle):
  - Quotient=Q, Remainder=R[N-1:0], DivZero=0.
  - Done=1 in this cycle only; Busy=0.
- Divide by zero: no RUN cycles. In the DONE cycle, Quotient = all ones, Remainder = captured Dividend, DivZero=1.
- Latency, with the Start edge counted as edge 0:
  - Busy=1 after edges 1..N.
  - Done=1 and outputs valid after edge N+1 (N=8: 9 cycles).
  - Div-by-zero: Done after edge 1.
- Outputs registered. Quotient, Remainder and DivZero change only on entering DONE and are stable otherwise.
- Start while Busy or in DONE: ignored, not queued. Operand inputs may change freely after acceptance.
- Start held high continuously: one operation is accepted each time IDLE is re-entered, giving back-to-back operations every N+2 cycles.
- RST mid-operation: aborts immediately to the reset values above; the pending result is discarded.
- Busy and Done are never both 1.

Test Plan:
- RST, then Start with Dividend=100, Divisor=7 (N=8) -> Busy high 8 cycles; Done pulse at edge 9; Quotient=14, Remainder=2, DivZero=0.
- Dividend=255, Divisor=1 -> Quotient=255, Remainder=0. Then 255/255 -> Quotient=1, Remainder=0. Then 5/9 -> Quotient=0, Remainder=5.
- Dividend=0x3C, Divisor=0 -> Done at edge 1, no Busy; Quotient=0xFF, Remainder=0x3C, DivZero=1. A following 10/3 -> Quotient=3, Remainder=1, DivZero=0.
- Start 200/13 (Quotient=15, Remainder=5); during Busy pulse Start with 9/3 -> ignored; result is 15/5 and exactly one Done pulse.
- Start 100/7, assert RST at edge 4 -> next cycle all outputs 0, state IDLE. New Start 50/6 -> Quotient=8, Remainder=2 at edge 9.
- Start held high with fixed 77/10 -> Done every 10 cycles; each result Quotient=7, Remainder=7; Busy never overlaps Done.
